// File: rtl/vga_pkg.sv
// Shared timing defaults, coordinate type and period helper for the VGA raster path.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int unsigned DEF_H_VISIBLE  = 640;
    localparam int unsigned DEF_H_FP       = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BP       = 48;
    localparam int unsigned DEF_V_VISIBLE  = 480;
    localparam int unsigned DEF_V_FP       = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BP       = 33;
    localparam int unsigned DEF_PIPE_DELAY = 2;

    // Full period of one axis: visible + front porch + sync + back porch.
    function automatic int unsigned span_total(
        input int unsigned visible,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return visible + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL = span_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = span_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_pipe_delay.sv
// Resettable shift register used to align raster flags with the mapper colour pipeline.
module vga_pipe_delay #(
    parameter int unsigned       WIDTH     = 1,
    parameter int unsigned       DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused;
        assign w_unused = i_clk ^ i_rst;
        assign o_q      = i_d;
    end else begin : g_shift
        logic [WIDTH-1:0] r_sr [DEPTH];

        // Shift one stage per clock; reset flushes every stage to the inactive value.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    r_sr[i] <= RESET_VAL;
                end
            end else begin
                r_sr[0] <= i_d;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    r_sr[i] <= r_sr[i-1];
                end
            end
        end

        assign o_q = r_sr[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/visible decode and pipeline alignment for the VGA output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       sof,
    output logic       eol,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
    localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t     r_x;
    coord_t     r_y;
    logic [7:0] r_frame_cnt;
    logic       r_sof;
    logic       r_eol;

    coord_t     w_x_nxt;
    coord_t     w_y_nxt;
    logic       w_x_wrap;
    logic       w_y_wrap;
    logic       w_vis;
    logic       w_hs_n;
    logic       w_vs_n;
    logic [1:0] w_sync_q;
    logic       w_blank_q;

    // Next counter values; wrap by comparing against the last index, never by overflow.
    always_comb begin
        w_x_wrap = (r_x == H_LAST);
        w_y_wrap = (r_y == V_LAST);
        w_x_nxt  = w_x_wrap ? '0 : r_x + 1'b1;
        w_y_nxt  = r_y;
        if (w_x_wrap) begin
            w_y_nxt = w_y_wrap ? '0 : r_y + 1'b1;
        end
    end

    // Counters plus sof/eol, which are decoded from the next coordinate so they line up with DrawX/DrawY.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
        end else begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_sof <= (w_x_nxt == '0) && (w_y_nxt == '0);
            r_eol <= (w_x_nxt == H_LAST);
            if (w_x_wrap && w_y_wrap) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Raw, undelayed decode of the current coordinate.
    always_comb begin
        w_vis  = (r_x < H_VIS_END) && (r_y < V_VIS_END);
        w_hs_n = !((r_x >= HS_START) && (r_x < HS_END));
        w_vs_n = !((r_y >= VS_START) && (r_y < VS_END));
    end

    vga_pipe_delay #(
        .WIDTH     (2),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (2'b11)
    ) u_sync_dly (
        .i_clk (vga_clk),
        .i_rst (reset),
        .i_d   ({w_hs_n, w_vs_n}),
        .o_q   (w_sync_q)
    );

    vga_pipe_delay #(
        .WIDTH     (1),
        .DEPTH     (PIPE_DELAY - 1),
        .RESET_VAL (1'b0)
    ) u_blank_dly (
        .i_clk (vga_clk),
        .i_rst (reset),
        .i_d   (w_vis),
        .o_q   (w_blank_q)
    );

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign sof         = r_sof;
    assign eol         = r_eol;
    assign frame_count = r_frame_cnt;
    assign hs          = w_sync_q[1];
    assign vs          = w_sync_q[0];
    assign blank       = w_blank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-width lines with a short frame (A), same with PIPE_DELAY=1 (B),
// and an 8x4 raster (C) for the frame counter wrap.
module tb_vga_timing_gen;

    logic clk;
    logic rst;
    logic rst_a;

    logic [9:0] ax, ay, bx, by, cx, cy;
    logic [7:0] afc, bfc, cfc;
    logic ablank, ahs, avs, asof, aeol;
    logic bblank, bhs, bvs, bsof, beol;
    logic cblank, chs, cvs, csof, ceol;

    int n_checks = 0;
    int n_pass   = 0;

    vga_timing_gen #(
        .V_VISIBLE (6), .V_FP (2), .V_SYNC (2), .V_BP (2), .PIPE_DELAY (2)
    ) dut_a (
        .vga_clk (clk), .reset (rst_a), .DrawX (ax), .DrawY (ay), .blank (ablank),
        .hs (ahs), .vs (avs), .sof (asof), .eol (aeol), .frame_count (afc)
    );

    vga_timing_gen #(
        .V_VISIBLE (6), .V_FP (2), .V_SYNC (2), .V_BP (2), .PIPE_DELAY (1)
    ) dut_b (
        .vga_clk (clk), .reset (rst), .DrawX (bx), .DrawY (by), .blank (bblank),
        .hs (bhs), .vs (bvs), .sof (bsof), .eol (beol), .frame_count (bfc)
    );

    vga_timing_gen #(
        .H_VISIBLE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_VISIBLE (1), .V_FP (1), .V_SYNC (1), .V_BP (1), .PIPE_DELAY (2)
    ) dut_c (
        .vga_clk (clk), .reset (rst), .DrawX (cx), .DrawY (cy), .blank (cblank),
        .hs (chs), .vs (cvs), .sof (csof), .eol (ceol), .frame_count (cfc)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    initial begin
        int hs_low_l0, hs_first, blank_fall, eol_first, eol_cnt;
        int vs_low, vs_first, sof_cnt, sof_first;
        int b_hs_first, b_blank_fall, b_vs_first;
        int post_hs_first, post_vs_low, guard;
        logic prev_ablank, prev_bblank;

        rst   = 1'b1;
        rst_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("rst_x",     32'(ax), 0);
        check("rst_y",     32'(ay), 0);
        check("rst_fc",    32'(afc), 0);
        check("rst_hs",    32'(ahs), 1);
        check("rst_vs",    32'(avs), 1);
        check("rst_blank", 32'(ablank), 0);
        check("rst_sof",   32'(asof), 0);
        check("rst_eol",   32'(aeol), 0);

        rst   = 1'b0;
        rst_a = 1'b0;

        check("exit_x",        32'(ax), 0);
        check("exit_y",        32'(ay), 0);
        check("exit_sof",      32'(asof), 0);
        check("exit_blank",    32'(ablank), 0);
        check("pd1_blank_x0",  32'(bblank), 1);

        hs_low_l0 = 0; hs_first = -1; blank_fall = -1; eol_first = -1; eol_cnt = 0;
        vs_low = 0; vs_first = -1; sof_cnt = 0; sof_first = -1;
        b_hs_first = -1; b_blank_fall = -1; b_vs_first = -1;
        prev_ablank = ablank;
        prev_bblank = bblank;

        for (int k = 1; k <= 9600; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("x_after_1",    32'(ax), 1);
                check("blank_x0_out", 32'(ablank), 1);
                check("hs_idle",      32'(ahs), 1);
            end
            if (k == 2) check("x_after_2", 32'(ax), 2);
            if (!ahs && k < 800) hs_low_l0++;
            if (!ahs && hs_first < 0) hs_first = k;
            if (prev_ablank && !ablank && blank_fall < 0) blank_fall = k;
            if (aeol) begin
                eol_cnt++;
                if (eol_first < 0) eol_first = k;
            end
            if (!avs) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
            if (asof) begin
                sof_cnt++;
                if (sof_first < 0) sof_first = k;
            end
            if (!bhs && b_hs_first < 0) b_hs_first = k;
            if (!bvs && b_vs_first < 0) b_vs_first = k;
            if (prev_bblank && !bblank && b_blank_fall < 0) b_blank_fall = k;
            if (k == 32) check("c_fc_first", 32'(cfc), 1);
            if (k == 8191) begin
                check("c_fc_pre_wrap", 32'(cfc), 255);
                check("c_x_pre_wrap",  32'(cx), 7);
                check("c_y_pre_wrap",  32'(cy), 3);
            end
            if (k == 8192) begin
                check("c_fc_wrap",  32'(cfc), 0);
                check("c_x_wrap",   32'(cx), 0);
                check("c_y_wrap",   32'(cy), 0);
                check("c_sof_wrap", 32'(csof), 1);
            end
            if (k == 9599) begin
                check("a_fc_pre_wrap", 32'(afc), 0);
                check("a_x_last",      32'(ax), 799);
                check("a_y_last",      32'(ay), 11);
            end
            prev_ablank = ablank;
            prev_bblank = bblank;
        end

        check("a_x_wrap",      32'(ax), 0);
        check("a_y_wrap",      32'(ay), 0);
        check("a_fc_wrap",     32'(afc), 1);
        check("a_sof_wrap",    32'(asof), 1);
        check("hs_low_len",    32'(hs_low_l0), 96);
        check("hs_first_low",  32'(hs_first), 658);
        check("blank_fall",    32'(blank_fall), 641);
        check("eol_first",     32'(eol_first), 799);
        check("eol_count",     32'(eol_cnt), 12);
        check("vs_low_len",    32'(vs_low), 1600);
        check("vs_first_low",  32'(vs_first), 6402);
        check("sof_count",     32'(sof_cnt), 1);
        check("sof_first",     32'(sof_first), 9600);
        check("pd1_hs_first",  32'(b_hs_first), 657);
        check("pd1_blank_fall", 32'(b_blank_fall), 640);
        check("pd1_vs_first",  32'(b_vs_first), 6401);

        guard = 0;
        while (!(ax == 10'd700 && ay == 10'd9) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("mid_reached", 32'(ax == 10'd700 && ay == 10'd9), 1);
        check("mid_hs_low",  32'(ahs), 0);
        check("mid_vs_low",  32'(avs), 0);

        rst_a = 1'b1;
        @(negedge clk);
        check("mid_rst_x",     32'(ax), 0);
        check("mid_rst_y",     32'(ay), 0);
        check("mid_rst_hs",    32'(ahs), 1);
        check("mid_rst_vs",    32'(avs), 1);
        check("mid_rst_blank", 32'(ablank), 0);
        check("mid_rst_fc",    32'(afc), 0);
        check("mid_rst_sof",   32'(asof), 0);
        check("mid_rst_eol",   32'(aeol), 0);
        rst_a = 1'b0;

        post_hs_first = -1;
        post_vs_low   = 0;
        for (int k = 1; k < 800; k++) begin
            @(negedge clk);
            if (!ahs && post_hs_first < 0) post_hs_first = k;
            if (!avs) post_vs_low++;
        end
        check("post_rst_hs_first", 32'(post_hs_first), 658);
        check("post_rst_vs_low",   32'(post_vs_low), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
